// File: rtl/bram_acc_rmw_if.sv
// Request/read/status bundle for bram_acc_rmw.
// The master drives requests and reads; the slave returns read data and status.
interface bram_acc_rmw_if #(
    parameter int AW         = 8,
    parameter int DIN_WIDTH  = 16,
    parameter int DOUT_WIDTH = 32
);
    logic                  wen;
    logic                  mode;
    logic [AW-1:0]         wadd;
    logic [DIN_WIDTH-1:0]  win;
    logic                  ren;
    logic [AW-1:0]         radd;
    logic [DOUT_WIDTH-1:0] rout;
    logic                  rvalid;
    logic                  clr;
    logic                  busy;
    logic                  ovf;

    modport master (output wen, mode, wadd, win, ren, radd, clr,
                    input  rout, rvalid, busy, ovf);
    modport slave  (input  wen, mode, wadd, win, ren, radd, clr,
                    output rout, rvalid, busy, ovf);
endinterface

// File: rtl/bram_acc_rmw.sv
// Block-RAM accumulator: overwrite/accumulate requests through a 2-stage RMW pipeline,
// a registered 2-cycle read port, and a drain-then-sweep clear FSM.
module bram_acc_rmw #(
    parameter int N_ADDR     = 256,
    parameter int DIN_WIDTH  = 16,
    parameter int DOUT_WIDTH = 32,
    parameter int SATURATE   = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    bram_acc_rmw_if.slave bus
);
    localparam int AW = $clog2(N_ADDR);

    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_e;
    typedef struct packed {
        logic                 mode;
        logic [AW-1:0]        addr;
        logic [DIN_WIDTH-1:0] din;
    } req_t;

    logic [DOUT_WIDTH-1:0] mem_q [N_ADDR] = '{default: '0};

    state_e                state_q, state_d;
    logic                  drain_cnt_q, drain_cnt_d;
    logic [AW-1:0]         sweep_q, sweep_d;
    logic                  busy, sweep_we, enter_drain;

    logic                  acc;
    logic [2:1]            vld_pipe_q;
    req_t                  s1_q, s2_q;
    logic [DOUT_WIDTH-1:0] base_q, base_sel, wdata;
    logic [DOUT_WIDTH:0]   sum;
    logic                  carry, commit;
    logic                  ovf_q;

    logic                  ren_q, rvalid_q;
    logic [AW-1:0]         radd_q;
    logic [DOUT_WIDTH-1:0] rout_q;

    // ---------------- clear FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            drain_cnt_q <= 1'b0;
            sweep_q     <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            sweep_q     <= sweep_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        sweep_d     = sweep_q;
        case (state_q)
            IDLE: if (bus.clr) begin
                state_d     = DRAIN;
                drain_cnt_d = 1'b0;
            end
            DRAIN: begin
                drain_cnt_d = ~drain_cnt_q;
                if (drain_cnt_q) begin
                    state_d = CLEAR;
                    sweep_d = '0;
                end
            end
            CLEAR: begin
                sweep_d = sweep_q + 1'b1;
                if (sweep_q == AW'(N_ADDR - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q != IDLE);
        sweep_we    = (state_q == CLEAR);
        enter_drain = (state_q == IDLE) && bus.clr;
    end

    // ---------------- RMW pipeline ----------------
    assign acc    = bus.wen && !busy && !bus.clr;
    assign commit = vld_pipe_q[2];

    always_ff @(posedge clk) begin
        if (!rst_n) vld_pipe_q <= '0;
        else        vld_pipe_q <= {vld_pipe_q[1], acc};
    end

    // The word committing this edge is not yet visible in mem_q, so forward it.
    always_ff @(posedge clk) begin
        s1_q   <= '{mode: bus.mode, addr: bus.wadd, din: bus.win};
        s2_q   <= s1_q;
        base_q <= (vld_pipe_q[2] && s2_q.addr == s1_q.addr) ? wdata : mem_q[s1_q.addr];
    end

    always_comb begin
        base_sel = s2_q.mode ? base_q : '0;
        sum      = {1'b0, base_sel} + {{(DOUT_WIDTH + 1 - DIN_WIDTH){1'b0}}, s2_q.din};
        carry    = sum[DOUT_WIDTH];
        wdata    = (carry && SATURATE != 0) ? '1 : sum[DOUT_WIDTH-1:0];
    end

    // Commits and sweep writes never overlap: DRAIN empties the pipeline first.
    always_ff @(posedge clk) begin
        if (rst_n && commit)        mem_q[s2_q.addr] <= wdata;
        else if (rst_n && sweep_we) mem_q[sweep_q]   <= '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= (enter_drain ? 1'b0 : ovf_q) | (commit & carry);
    end

    // ---------------- read port ----------------
    // Address is registered first, so the array read sees all commits up to the request edge.
    always_ff @(posedge clk) begin
        radd_q <= bus.radd;
        if (!rst_n) begin
            ren_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rout_q   <= '0;
        end else begin
            ren_q    <= bus.ren;
            rvalid_q <= ren_q;
            if (ren_q) rout_q <= mem_q[radd_q];
        end
    end

    assign bus.rout   = rout_q;
    assign bus.rvalid = rvalid_q;
    assign bus.busy   = busy;
    assign bus.ovf    = ovf_q;
endmodule
